// File: rtl/ssd_scan_arbiter.sv
// ssd_scan_arbiter: two-client 8-digit seven-segment scanner with frame-granular round-robin ownership
module ssd_scan_arbiter #(
  parameter int SCAN_DIV  = 262144,
  parameter int BLANK_CYC = 1024
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        req_a,
  input  logic        req_b,
  input  logic [31:0] data_a,
  input  logic [31:0] data_b,
  input  logic [7:0]  mask_a,
  input  logic [7:0]  mask_b,
  input  logic [7:0]  dp_a,
  input  logic [7:0]  dp_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] BLANK = PW'(BLANK_CYC);
  localparam logic [15:0][6:0] SEG = {7'h38, 7'h30, 7'h42, 7'h31, 7'h60, 7'h08, 7'h04, 7'h00,
                                      7'h0F, 7'h20, 7'h24, 7'h4C, 7'h06, 7'h12, 7'h4F, 7'h01};
  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
  state_t state, state_nx;
  logic [PW-1:0] ps;
  logic [2:0] idx;
  logic last_b, last_b_nx, bnd, lit;
  logic [31:0] sh_data;
  logic [7:0] sh_mask, sh_dp;
  logic [3:0] nib;
  assign bnd = (ps == LAST) && (idx == 3'd7);
  assign nib = sh_data[{idx, 2'b00} +: 4];
  assign lit = (ps >= BLANK) && sh_mask[idx];
  // prescaler and digit index; the index steps each time the prescaler wraps
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      ps  <= '0;
      idx <= '0;
    end else begin
      ps <= (ps == LAST) ? '0 : ps + 1'b1;
      if (ps == LAST) idx <= idx + 3'd1;
    end
  end
  // arbitration decided only at frame boundaries; on contention the last owner yields
  always_comb begin
    state_nx  = state;
    last_b_nx = last_b;
    if (bnd) begin
      state_nx  = (req_a && req_b) ? (last_b ? OWN_A : OWN_B) :
                  req_a ? OWN_A : req_b ? OWN_B : IDLE;
      last_b_nx = (state_nx == OWN_B) ? 1'b1 : (state_nx == OWN_A) ? 1'b0 : last_b;
    end
  end
  // ownership, grants, frame pulse and per-frame snapshot of the owner's display data
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_b     <= 1'b1;
      gnt_a      <= 1'b0;
      gnt_b      <= 1'b0;
      frame_done <= 1'b0;
      sh_data    <= '0;
      sh_mask    <= '0;
      sh_dp      <= '0;
    end else begin
      state      <= state_nx;
      last_b     <= last_b_nx;
      gnt_a      <= state_nx == OWN_A;
      gnt_b      <= state_nx == OWN_B;
      frame_done <= bnd;
      if (bnd) begin
        sh_data <= (state_nx == OWN_A) ? data_a : (state_nx == OWN_B) ? data_b : '0;
        sh_mask <= (state_nx == OWN_A) ? mask_a : (state_nx == OWN_B) ? mask_b : '0;
        sh_dp   <= (state_nx == OWN_A) ? dp_a   : (state_nx == OWN_B) ? dp_b   : '0;
      end
    end
  end
  // registered display drive from the snapshot; dark during the blanking head of each slot
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      an  <= 8'hFF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= lit ? ~(8'b1 << idx) : 8'hFF;
      seg <= lit ? SEG[nib] : 7'h7F;
      dp  <= ~(lit & sh_dp[idx]);
    end
  end
endmodule

// File: tb/tb_ssd_scan_arbiter.sv
// tb_ssd_scan_arbiter: directed vector table plus reset corner sequence for the scan arbiter
module tb_ssd_scan_arbiter;
  logic Clk = 1'b0, reset_n = 1'b0;
  logic req_a, req_b, gnt_a, gnt_b, dp, frame_done;
  logic [31:0] data_a, data_b;
  logic [7:0] mask_a, mask_b, dp_a, dp_b, an;
  logic [6:0] seg;
  int ecnt = 0, checks = 0, failures = 0;
  typedef struct {
    int e;
    int p;
    logic [7:0] an;
    logic [6:0] seg;
    logic dp, ga, gb, fd;
  } vec_t;
  vec_t v[$];

  ssd_scan_arbiter #(.SCAN_DIV(16), .BLANK_CYC(4)) dut (
    .Clk(Clk), .reset_n(reset_n), .req_a(req_a), .req_b(req_b),
    .data_a(data_a), .data_b(data_b), .mask_a(mask_a), .mask_b(mask_b),
    .dp_a(dp_a), .dp_b(dp_b), .gnt_a(gnt_a), .gnt_b(gnt_b),
    .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk or negedge reset_n)
    if (!reset_n) ecnt <= 0;
    else ecnt <= ecnt + 1;

  task automatic add(input int e, input int p, input logic [7:0] a, input logic [6:0] s,
                     input logic d, input logic ga, input logic gb, input logic fd);
    vec_t r;
    r.e = e; r.p = p; r.an = a; r.seg = s; r.dp = d; r.ga = ga; r.gb = gb; r.fd = fd;
    v.push_back(r);
  endtask

  task automatic apply(input int p);
    req_a  = (p <= 1);
    req_b  = (p != 0 && p != 4);
    data_a = 32'h76543210;
    data_b = (p <= 1) ? 32'hFEDCBA98 : (p == 2) ? 32'h0 : 32'hFFFFFFFF;
    mask_a = 8'hFF;
    mask_b = (p == 2) ? 8'h0F : 8'hFF;
    dp_a   = 8'h01;
    dp_b   = 8'h80;
  endtask

  task automatic chk(input string nm, input int e, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%h want=%h", nm, e, act, exp);
    end
  endtask

  task automatic at_edge(input int e);
    int n = 0;
    do begin
      @(posedge Clk);
      #1;
      n++;
    end while (ecnt != e && n < 3000);
    if (ecnt != e) begin
      checks++;
      failures++;
      $display("FAIL timeout edge got=%0d want=%0d", ecnt, e);
    end
  endtask

  initial begin
    apply(0);
    add(1,   0, 8'hFF, 7'h7F, 1, 0, 0, 0);
    add(64,  0, 8'hFF, 7'h7F, 1, 0, 0, 0);
    add(127, 0, 8'hFF, 7'h7F, 1, 0, 0, 0);
    add(128, 0, 8'hFF, 7'h7F, 1, 1, 0, 1);
    add(129, 0, 8'hFF, 7'h7F, 1, 1, 0, 0);
    add(132, 0, 8'hFF, 7'h7F, 1, 1, 0, 0);
    add(133, 0, 8'hFE, 7'h01, 0, 1, 0, 0);
    add(149, 0, 8'hFD, 7'h4F, 1, 1, 0, 0);
    add(200, 1, 8'hEF, 7'h4C, 1, 1, 0, 0);
    add(256, 1, 8'h7F, 7'h0F, 1, 0, 1, 1);
    add(257, 1, 8'hFF, 7'h7F, 1, 0, 1, 0);
    add(261, 1, 8'hFE, 7'h00, 1, 0, 1, 0);
    add(373, 1, 8'h7F, 7'h38, 0, 0, 1, 0);
    add(384, 1, 8'h7F, 7'h38, 0, 1, 0, 1);
    add(385, 1, 8'hFF, 7'h7F, 1, 1, 0, 0);
    add(389, 1, 8'hFE, 7'h01, 0, 1, 0, 0);
    add(400, 2, 8'hFE, 7'h01, 0, 1, 0, 0);
    add(450, 2, 8'hFF, 7'h7F, 1, 1, 0, 0);
    add(512, 2, 8'h7F, 7'h0F, 1, 0, 1, 1);
    add(550, 3, 8'hFB, 7'h01, 1, 0, 1, 0);
    add(565, 3, 8'hF7, 7'h01, 1, 0, 1, 0);
    add(571, 3, 8'hF7, 7'h01, 1, 0, 1, 0);
    add(585, 3, 8'hFF, 7'h7F, 1, 0, 1, 0);
    add(640, 3, 8'hFF, 7'h7F, 1, 0, 1, 1);
    add(693, 3, 8'hF7, 7'h38, 1, 0, 1, 0);
    add(700, 4, 8'hF7, 7'h38, 1, 0, 1, 0);
    add(725, 4, 8'hDF, 7'h38, 1, 0, 1, 0);
    add(768, 4, 8'h7F, 7'h38, 0, 0, 0, 1);
    add(780, 3, 8'hFF, 7'h7F, 1, 0, 0, 0);
    add(805, 3, 8'hFF, 7'h7F, 1, 0, 0, 0);
    add(896, 3, 8'hFF, 7'h7F, 1, 0, 1, 1);
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_an", 0, an, 8'hFF);
    chk("rst_seg", 0, seg, 7'h7F);
    chk("rst_dp", 0, dp, 1'b1);
    chk("rst_gnt", 0, {gnt_a, gnt_b}, 2'b00);
    chk("rst_fd", 0, frame_done, 1'b0);
    @(negedge Clk);
    reset_n = 1'b1;
    foreach (v[i]) begin
      at_edge(v[i].e);
      chk("an", v[i].e, an, v[i].an);
      chk("seg", v[i].e, seg, v[i].seg);
      chk("dp", v[i].e, dp, v[i].dp);
      chk("gnt_a", v[i].e, gnt_a, v[i].ga);
      chk("gnt_b", v[i].e, gnt_b, v[i].gb);
      chk("frame_done", v[i].e, frame_done, v[i].fd);
      apply(v[i].p);
    end
    at_edge(984);
    chk("pre_rst_an", 984, an, 8'hDF);
    chk("pre_rst_seg", 984, seg, 7'h38);
    chk("pre_rst_gnt_b", 984, gnt_b, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst_an", 984, an, 8'hFF);
    chk("async_rst_seg", 984, seg, 7'h7F);
    chk("async_rst_dp", 984, dp, 1'b1);
    chk("async_rst_gnt_b", 984, gnt_b, 1'b0);
    @(negedge Clk);
    reset_n = 1'b1;
    for (int e = 1; e < 128; e++) begin
      at_edge(e);
      chk("redark", e, {an, seg, dp, gnt_a, gnt_b, frame_done}, {8'hFF, 7'h7F, 1'b1, 3'b000});
    end
    at_edge(128);
    chk("regrant", 128, {gnt_a, gnt_b, frame_done}, 3'b011);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
